ifetch_stage: RTL and testbench

//   Instruction-fetch stage of the pipelined MIPS subset. Holds the PC and drives the combinational

---
 rtl/ifetch_stage.sv | 112 +++++++++++
 tb/tb_ifetch_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID pipeline register, honouring redirect, stall and flush.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        misalign_err
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] pc_plus4_s;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state selection for PC and IF/ID, in redirect > stall > flush > fetch priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d    = {redirect_target[31:2], 2'b00};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else if (stall) begin
          // A squash during a stall still bubbles IF/ID while the PC holds.
          if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else begin
            instr_d = instr_q;
            valid_d = valid_q;
          end
        end else if (flush) begin
          pc_d    = pc_plus4_s;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus4_s;
          instr_d = imem_data;
          pc4_d   = pc_plus4_s;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc4     = pc4_q;
  assign ifid_valid   = valid_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a vector table for the steady-state sequence
// plus hand-written reset / boot sequences.
module tb_ifetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        misalign_err;

  logic [31:0] rom [64];
  logic        xdata;
  int          total;
  int          bad;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] tgt;
    logic        xd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  ifetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc              (pc),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .misalign_err    (misalign_err)
  );

  assign imem_data = xdata ? 32'hxxxx_xxxx : rom[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_err);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr"}, ifid_instr, e_instr);
    check({tag, ".pc4"}, ifid_pc4, e_pc4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    check({tag, ".err"}, {31'd0, misalign_err}, {31'd0, e_err});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h2009_0000;
    rom[1]  = 32'h2129_0005;
    rom[2]  = 32'h2001_0019;
    rom[3]  = 32'h3c01_1234;
    rom[4]  = 32'hac01_0000;
    rom[63] = 32'h1111_1111;

    //          stall flush redir target        xd    pc            instr         pc4           v     err
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 32'h2009_0000, 32'h0000_0004, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 32'h2001_0019, 32'h0000_000C, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0010, 32'h3c01_1234, 32'h0000_0010, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h0000_0010, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0010, 32'h3c01_1234, 32'h0000_0010, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'h0000_0010, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0008, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 32'h2009_0000, 32'h0000_0004, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 32'h2129_0005, 32'h0000_0008, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C, 32'h2001_0019, 32'h0000_000C, 1'b1, 1'b1};

    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0000_0000;
    xdata = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // BOOT cycle: inputs are ignored, even an aggressive redirect.
    @(negedge clk);
    reset = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h0000_0042;
    @(posedge clk);
    #1;
    check_all("boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      stall = vecs[i].stall;
      flush = vecs[i].flush;
      redirect = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      xdata = vecs[i].xd;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                vecs[i].e_valid, vecs[i].e_err);
    end

    // Asynchronous reset mid-stream at pc=0xC, observed before any clock edge.
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    xdata = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("reboot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("refetch0", 32'h4, 32'h2009_0000, 32'h4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_all("refetch1", 32'h8, 32'h2129_0005, 32'h8, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
